// File: rtl/grey_filter_pkg.sv
// Shared widths, mode encodings and the 8-bit clamp for the grey Sobel stage.
package grey_filter_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned GRAD_W       = 11;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'b00,
        MODE_MAG     = 2'b01,
        MODE_BIN     = 2'b10,
        MODE_MAG_ALT = 2'b11
    } mode_e;

    // Clamp an edge magnitude to the 8-bit pixel range.
    function automatic logic [PIX_W-1:0] sat8(input logic [GRAD_W-1:0] m);
        return (m > GRAD_W'(255)) ? '1 : m[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/grey_line_ram.sv
// Simple dual-port line buffer with synchronous read; a read and write at the
// same address return the old word.
module grey_line_ram #(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/grey_sobel_filter.sv
// 3x3 Sobel edge-magnitude stage on the grey pixel stream: line buffers, window,
// gradient and mode/threshold output with a fixed three-cycle latency.
module grey_sobel_filter
    import grey_filter_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned COL_W    = 10,
    parameter int unsigned ROW_W    = 10
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iDVAL,
    input  logic [PIX_W-1:0] iGrey,
    input  logic             iFRAME_START,
    input  logic [1:0]       iMODE,
    input  logic [PIX_W-1:0] iTHRESH,
    output logic             oDVAL,
    output logic [PIX_W-1:0] oGrey
);

    localparam int unsigned      LAT      = 3;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = '1;

    function automatic logic [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b,
                                               input logic [PIX_W-1:0] c);
        return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
    endfunction

    logic [COL_W-1:0] col, col_cur, col_nxt, col_d;
    logic [ROW_W-1:0] row, row_cur, row_nxt;
    logic [LAT-1:0]   vld_sr;
    logic [PIX_W-1:0] grey_d, up1, up2, centre;
    logic             border_d, border_q;
    logic [2:0][1:0][PIX_W-1:0] win;
    logic [2:0][PIX_W-1:0]      colv;
    logic [GRAD_W-1:0] gx, gy, gx_c, gy_c, ax_c, ay_c;
    logic [PIX_W-1:0]  sat_c, pix_c;

    // Position of the current pixel; a coincident frame start makes it (0,0).
    always_comb begin
        col_cur = iFRAME_START ? '0 : col;
        row_cur = iFRAME_START ? '0 : row;
        col_nxt = col_cur;
        row_nxt = row_cur;
        if (iDVAL) begin
            if (col_cur == COL_LAST) begin
                col_nxt = '0;
                if (row_cur != ROW_MAX) row_nxt = row_cur + ROW_W'(1);
            end else begin
                col_nxt = col_cur + COL_W'(1);
            end
        end
    end

    // Row-1 buffer takes the live pixel; row-2 buffer takes row-1's old word a cycle later.
    grey_line_ram #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_ram0 (
        .clk(iCLK), .wr_en(iDVAL), .wr_addr(col_cur), .wr_data(iGrey),
        .rd_en(iDVAL), .rd_addr(col_cur), .rd_data(up1)
    );

    grey_line_ram #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_ram1 (
        .clk(iCLK), .wr_en(vld_sr[0]), .wr_addr(col_d), .wr_data(up1),
        .rd_en(iDVAL), .rd_addr(col_cur), .rd_data(up2)
    );

    // Newest window column comes straight from the stage-0 registers.
    assign colv[0] = up2;
    assign colv[1] = up1;
    assign colv[2] = grey_d;

    always_comb begin
        gx_c = wsum(colv[0], colv[1], colv[2]) - wsum(win[0][0], win[1][0], win[2][0]);
        gy_c = wsum(win[2][0], win[2][1], colv[2]) - wsum(win[0][0], win[0][1], colv[0]);
    end

    always_comb begin
        ax_c  = gx[GRAD_W-1] ? (GRAD_W'(0) - gx) : gx;
        ay_c  = gy[GRAD_W-1] ? (GRAD_W'(0) - gy) : gy;
        sat_c = sat8(ax_c + ay_c);
        pix_c = '0;
        case (iMODE)
            MODE_BYPASS: pix_c = centre;
            MODE_BIN:    pix_c = (!border_q && (sat_c >= iTHRESH)) ? '1 : '0;
            default:     pix_c = border_q ? '0 : sat_c;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            col      <= '0;
            row      <= '0;
            vld_sr   <= '0;
            col_d    <= '0;
            grey_d   <= '0;
            border_d <= 1'b0;
            win      <= '0;
            gx       <= '0;
            gy       <= '0;
            centre   <= '0;
            border_q <= 1'b0;
            oGrey    <= '0;
        end else begin
            col    <= col_nxt;
            row    <= row_nxt;
            vld_sr <= {vld_sr[LAT-2:0], iDVAL};
            if (iDVAL) begin
                col_d    <= col_cur;
                grey_d   <= iGrey;
                border_d <= (row_cur < ROW_W'(2)) || (col_cur < COL_W'(2));
            end
            if (vld_sr[0]) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= colv[r];
                end
                gx       <= gx_c;
                gy       <= gy_c;
                centre   <= win[1][1];
                border_q <= border_d;
            end
            if (vld_sr[1]) oGrey <= pix_c;
        end
    end

    assign oDVAL = vld_sr[LAT-1];

endmodule

// File: tb/tb_grey_sobel_filter.sv
// Scoreboard bench for grey_sobel_filter against an image-level Sobel model.
module tb_grey_sobel_filter;

    localparam int H = 640;

    typedef struct {
        logic [7:0] val;
        bit         chk;
        int         col;
        int         row;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, dval, fs, odval;
    logic [7:0] grey, thresh, ogrey;
    logic [1:0] mode;

    grey_sobel_filter #(.H_ACTIVE(H), .COL_W(10), .ROW_W(10)) dut (
        .iCLK(clk), .iRESET(rst), .iDVAL(dval), .iGrey(grey),
        .iFRAME_START(fs), .iMODE(mode), .iTHRESH(thresh),
        .oDVAL(odval), .oGrey(ogrey)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   out_cnt = 0;
    exp_t exp_q[$];
    logic [2:0] hist = 3'b000;

    // Reference state: last two rows per column, last two window columns.
    int m_col, m_row;
    int line1 [H];
    int line2 [H];
    bit k1 [H];
    bit k2 [H];
    int hc [2][3];
    bit hk [2];
    int kw [3] = '{1, 2, 1};

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        for (int c = 0; c < H; c++) begin
            k1[c] = 1'b0;
            k2[c] = 1'b0;
        end
        for (int j = 0; j < 2; j++) begin
            hk[j] = 1'b1;
            for (int i = 0; i < 3; i++) hc[j][i] = 0;
        end
    endtask

    task automatic model_push(input int g, input bit f);
        int w [3][3];
        int c, r, gx, gy, mag, sat, v;
        bit newk, border, known;
        exp_t e;
        if (f) begin
            m_col = 0;
            m_row = 0;
        end
        c = m_col;
        r = m_row;
        for (int i = 0; i < 3; i++) begin
            w[i][0] = hc[0][i];
            w[i][1] = hc[1][i];
        end
        w[0][2] = line2[c];
        w[1][2] = line1[c];
        w[2][2] = g;
        newk  = k1[c] && k2[c];
        known = hk[0] && hk[1] && newk;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            gx += kw[i] * (w[i][2] - w[i][0]);
            gy += kw[i] * (w[2][i] - w[0][i]);
        end
        mag    = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sat    = (mag > 255) ? 255 : mag;
        border = (r < 2) || (c < 2);
        case (mode)
            2'b00: begin v = w[1][1]; e.chk = hk[1]; end
            2'b10: begin v = border ? 0 : ((sat >= int'(thresh)) ? 255 : 0); e.chk = border || known; end
            default: begin v = border ? 0 : sat; e.chk = border || known; end
        endcase
        e.val = 8'(v);
        e.col = c;
        e.row = r;
        exp_q.push_back(e);
        line2[c] = line1[c];
        k2[c]    = k1[c];
        line1[c] = g;
        k1[c]    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hc[0][i] = hc[1][i];
            hc[1][i] = w[i][2];
        end
        hk[0] = hk[1];
        hk[1] = newk;
        m_col++;
        if (m_col == H) begin
            m_col = 0;
            if (m_row < 1023) m_row++;
        end
    endtask

    task automatic cyc(input bit v, input int g, input bit f);
        dval = v;
        grey = 8'(g);
        fs   = f;
        if (v) model_push(g, f);
        else if (f) begin
            m_col = 0;
            m_row = 0;
        end
        @(posedge clk);
        #2;
        dval = 1'b0;
        fs   = 1'b0;
    endtask

    function automatic int pattern(input int kind, input int c);
        case (kind)
            0: return 100;
            1: return (c < 320) ? 0 : 200;
            2: return c & 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic run_frame(input int kind, input int npix, input int gap, input bit start);
        if (start) cyc(1'b0, 0, 1'b1);
        for (int k = 0; k < npix; k++) begin
            cyc(1'b1, pattern(kind, k % H), 1'b0);
            if (gap > 0 && (k % gap) == gap - 1) repeat (10) cyc(1'b0, 0, 1'b0);
        end
        repeat (6) cyc(1'b0, 0, 1'b0);
    endtask

    // Monitor: oDVAL must be the input strobe delayed three cycles; pixels checked in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hist = 3'b000;
        end else begin
            n_tests++;
            if (odval !== hist[2]) begin
                n_fail++;
                $display("FAIL odval_timing t=%0t got=%b want=%b", $time, odval, hist[2]);
            end
            hist = {hist[1:0], dval};
            if (odval === 1'b1) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output t=%0t got=%0d", $time, ogrey);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk) begin
                        n_tests++;
                        if (ogrey !== e.val) begin
                            n_fail++;
                            $display("FAIL pixel col=%0d row=%0d mode=%0d got=%0d want=%0d",
                                     e.col, e.row, mode, ogrey, e.val);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int start_cnt;
        rst = 1'b1; dval = 1'b0; fs = 1'b0; grey = '0;
        mode = 2'b01; thresh = 8'd128;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (odval !== 1'b0) begin n_fail++; $display("FAIL reset_odval got=%b want=0", odval); end
        n_tests++;
        if (ogrey !== 8'd0) begin n_fail++; $display("FAIL reset_ogrey got=%0d want=0", ogrey); end
        #1 rst = 1'b0;
        @(posedge clk); #2;

        mode = 2'b01;
        start_cnt = out_cnt;
        run_frame(0, 4 * H, 0, 1'b1);
        n_tests++;
        if (out_cnt - start_cnt != 4 * H) begin
            n_fail++;
            $display("FAIL flat_count got=%0d want=%0d", out_cnt - start_cnt, 4 * H);
        end

        run_frame(1, 4 * H, 0, 1'b1);
        mode = 2'b10; thresh = 8'd128;
        run_frame(1, 4 * H, 0, 1'b1);
        thresh = 8'd255;
        run_frame(1, 4 * H, 0, 1'b1);

        mode = 2'b00;
        run_frame(2, 3 * H, 0, 1'b1);

        mode = 2'b01;
        run_frame(3, 3 * H + 60, 37, 1'b1);
        mode = 2'b11;
        run_frame(3, 3 * H, 0, 1'b1);
        mode = 2'b10; thresh = 8'($urandom_range(1, 254));
        run_frame(3, 3 * H, 37, 1'b1);

        mode = 2'b01;
        run_frame(3, 300, 0, 1'b1);
        cyc(1'b1, pattern(1, 0), 1'b1);
        run_frame(1, 3 * H - 1, 0, 1'b0);

        cyc(1'b0, 0, 1'b1);
        for (int k = 0; k < 2 * H + 100; k++) cyc(1'b1, pattern(3, 0), 1'b0);
        n_tests++;
        if (odval !== 1'b1) begin n_fail++; $display("FAIL pre_reset_odval got=%b want=1", odval); end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (odval !== 1'b0 || ogrey !== 8'd0) begin
            n_fail++;
            $display("FAIL midline_reset odval=%b ogrey=%0d want 0/0", odval, ogrey);
        end
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        run_frame(1, 3 * H, 0, 1'b0);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
